gray_decode_tracker: RTL and testbench
======================================

// Module: gray_decode_tracker
// PURPOSE
//  Registered Gray-to-binary decoder with valid/ready handshake. Receive-side counterpart of the
//  team's binary-to-Gray encoder. Consumes Gray-coded samples (e.g. from a rotary encoder or a
//  Gray-coded pointer), emits the binary value, and classifies each sample against the previous
//  accepted one as step-up, step-down, hold or illegal jump. Sits between the Gray source and
//  downstream counting/display logic.
// PARAMETERS
//  WIDTH    4   code width in bits (>=2)
// PORTS
//  clk         in   1      single clock, rising edge
//  rst_n       in   1      asynchronous active-low reset
//  in_valid    in   1      gray_in holds a sample
//  in_ready    out  1      block can accept a sample this cycle
//  gray_in     in   WIDTH  Gray-coded sample
//  out_valid   out  1      result registers hold an unconsumed result
//  out_ready   in   1      downstream consumes the result this cycle
//  binary_out  out  WIDTH  decoded binary value
//  step_up     out  1      binary_out == prev+1 (mod 2^WIDTH)
//  step_down   out  1      binary_out == prev-1 (mod 2^WIDTH)
//  step_err    out  1      binary_out differs from prev by more than 1 (mod 2^WIDTH)
// BEHAVIOUR
//  - One clock; reset asynchronous and active-low. All flops clear on the falling edge of rst_n,
//    independent of clk.
//  - Reset values: out_valid=0, binary_out=0, step_up/step_down/step_err=0. Internal prev=0, have_prev=0.
//    Reset mid-transfer drops the held result. The first sample after reset is treated as a first sample.
//  - in_ready = !out_valid || out_ready. This is combinational and is the only combinational
//    in->out path.
//  - Accept occurs when in_valid && in_ready. On accept, in the same edge:
//    binary_out <= decode(gray_in); out_valid <= 1; prev <= decode(gray_in); have_prev <= 1.
//  - Decode: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i] for i = WIDTH-2..0.
//  - Latency: 1 cycle (result visible the cycle after accept). Throughput: 1 sample per cycle
//    while out_ready=1.
//  - Classification on accept, with d = decode(gray_in):
//      have_prev=0           -> all flags 0 (first sample)
//      d == prev             -> all flags 0 (hold)
//      d == prev+1 mod 2^W   -> step_up=1
//      d == prev-1 mod 2^W   -> step_down=1
//      otherwise             -> step_err=1
//    At most one flag is high. Flags are only meaningful while out_valid=1.
//  - Wrap-around: prev=2^W-1, d=0 -> step_up. prev=0, d=2^W-1 -> step_down. All arithmetic is
//    WIDTH bits and truncating.
//  - Stall: out_valid && !out_ready -> binary_out and flags hold, in_ready=0, gray_in ignored.
//  - No accept && out_ready -> out_valid <= 0. binary_out, flags and prev keep their last values.
//  - Simultaneous consume and accept (out_valid && out_ready && in_valid): new result loads
//    and out_valid stays 1. No bubble.
//  - X/Z on gray_in when in_valid=0 must not affect state.
// STRUCTURE
//  - Shared package gray_pkg:
//      localparam GRAY_W_DEFAULT = 4
//      function gray2bin(WIDTH) and function bin2gray(WIDTH), reused by the encoder and
//      by this block's bench.
//  - Sub-module gray_to_bin_comb: purely combinational decoder, parameter WIDTH.
//    Instantiated once on gray_in.
//  - Top holds the handshake/output register, prev/have_prev, and the +/-1 mod-2^W comparators.
// TESTING
//  - Reset: assert rst_n=0 asynchronously mid-cycle with in_valid=1 ->
//    out_valid=0, binary_out=0, flags=0 immediately. Next accept raises no flag.
//  - Decode sweep: feed Gray 0000,0001,0011,0010,0110 with out_ready=1 ->
//    binary_out 0,1,2,3,4 one cycle later, step_up=1 on all but the first.
//  - Wrap/down: feed Gray 1000 (bin 15), then 0000 -> step_up.
//    Then feed 1000 -> step_down. Then 0000 again -> step_up.
//  - Illegal jump: feed 0001 (1), then 0110 (4) -> step_err=1, binary_out=4.
//    Then repeat 0110 -> all flags 0 (hold).
//  - Backpressure: out_ready=0 for 3 cycles with in_valid=1 ->
//    in_ready=0, binary_out frozen, no sample lost. Release -> next sample appears the
//    following cycle, out_valid stays 1 (no bubble).
//  - Random: 1000 random Gray samples with random in_valid/out_ready ->
//    scoreboard built from gray2bin/prev matches every output. Exactly 0 or 1 flags high
//    whenever out_valid=1.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and defaults. The encoder and the decode tracker
// (and its bench) import this package.
package gray_pkg;

    localparam int GRAY_W_DEFAULT = 4;
    localparam int GRAY_W_MAX     = 32;

    typedef enum logic [1:0] {
        STEP_HOLD,
        STEP_UP,
        STEP_DOWN,
        STEP_ERR
    } step_kind_e;

    // Codes narrower than GRAY_W_MAX are zero-extended. Leading zeros leave
    // every lower bit's prefix-XOR unchanged, so these functions serve any WIDTH.
    function automatic logic [GRAY_W_MAX-1:0] gray2bin(input logic [GRAY_W_MAX-1:0] g);
        logic [GRAY_W_MAX-1:0] b;
        b = g;
        for (int i = GRAY_W_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [GRAY_W_MAX-1:0] bin2gray(input logic [GRAY_W_MAX-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_decode_tracker_if.sv
// Handshake bundle of the Gray decode tracker: the Gray sample input side and
// the decoded-result output side.
interface gray_decode_tracker_if
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_W_DEFAULT
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] gray_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] binary_out;
    logic             step_up;
    logic             step_down;
    logic             step_err;

    modport slave (
        input  in_valid,
        input  gray_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output binary_out,
        output step_up,
        output step_down,
        output step_err
    );

    modport master (
        output in_valid,
        output gray_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  binary_out,
        input  step_up,
        input  step_down,
        input  step_err
    );

endinterface

// File: rtl/gray_to_bin_comb.sv
// Purely combinational Gray-to-binary decoder of parameterisable width.
module gray_to_bin_comb
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_W_DEFAULT
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    always_comb begin
        bin_o = WIDTH'(gray2bin(GRAY_W_MAX'(gray_i)));
    end

endmodule

// File: rtl/gray_decode_tracker.sv
// Registered Gray-to-binary decoder with valid/ready handshake that classifies
// each accepted sample against the previous one (up, down, hold, illegal jump).
module gray_decode_tracker
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gray_decode_tracker_if.slave  bus
);

    logic [WIDTH-1:0] decoded;
    logic             accept;
    logic             in_ready;
    step_kind_e       kind;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] binary_q,    binary_d;
    logic             step_up_q,   step_up_d;
    logic             step_down_q, step_down_d;
    logic             step_err_q,  step_err_d;
    logic [WIDTH-1:0] prev_q,      prev_d;
    logic             have_prev_q, have_prev_d;

    gray_to_bin_comb #(
        .WIDTH (WIDTH)
    ) u_decode (
        .gray_i (bus.gray_in),
        .bin_o  (decoded)
    );

    assign in_ready = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;

    // Modulo-2^WIDTH neighbours of prev; the first sample after reset is never classified.
    always_comb begin
        kind = STEP_HOLD;
        if (have_prev_q && (decoded != prev_q)) begin
            if (decoded == prev_q + WIDTH'(1)) begin
                kind = STEP_UP;
            end else if (decoded == prev_q - WIDTH'(1)) begin
                kind = STEP_DOWN;
            end else begin
                kind = STEP_ERR;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        binary_d    = binary_q;
        step_up_d   = step_up_q;
        step_down_d = step_down_q;
        step_err_d  = step_err_q;
        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        if (accept) begin
            out_valid_d = 1'b1;
            binary_d    = decoded;
            step_up_d   = (kind == STEP_UP);
            step_down_d = (kind == STEP_DOWN);
            step_err_d  = (kind == STEP_ERR);
            prev_d      = decoded;
            have_prev_d = 1'b1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            binary_q    <= '0;
            step_up_q   <= 1'b0;
            step_down_q <= 1'b0;
            step_err_q  <= 1'b0;
            prev_q      <= '0;
            have_prev_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            binary_q    <= binary_d;
            step_up_q   <= step_up_d;
            step_down_q <= step_down_d;
            step_err_q  <= step_err_d;
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.binary_out = binary_q;
    assign bus.step_up    = step_up_q;
    assign bus.step_down  = step_down_q;
    assign bus.step_err   = step_err_q;

endmodule

// File: tb/tb_gray_decode_tracker.sv
// Scoreboard bench for gray_decode_tracker: expected results are queued on
// accept and compared while the DUT holds them.
module tb_gray_decode_tracker;
    import gray_pkg::*;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] bin;
        logic         up;
        logic         dn;
        logic         err;
    } exp_t;

    logic clk;
    logic rst_n;

    gray_decode_tracker_if #(.WIDTH(W)) bus ();

    gray_decode_tracker #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference state: what the block should currently hold.
    exp_t         exp_q[$];
    logic         m_valid;
    logic         m_have;
    logic [W-1:0] m_prev;
    int           tests_run;
    int           tests_failed;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        tests_run++;
        if (got !== expv) begin
            tests_failed++;
            $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, expv, $time);
        end
    endtask

    function automatic exp_t model_result(input logic [W-1:0] g);
        exp_t         r;
        logic [W-1:0] diff;
        r.bin = W'(gray2bin(32'(g)));
        diff  = r.bin - m_prev;
        r.up  = m_have && (diff == 4'h1);
        r.dn  = m_have && (diff == 4'hF);
        r.err = m_have && (diff != 4'h0) && !r.up && !r.dn;
        return r;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_valid = 1'b0;
        m_have  = 1'b0;
        m_prev  = '0;
    endtask

    // One cycle: drive at negedge, check just after, advance the model to the next posedge.
    task automatic applyStimulus(input string tag, input logic iv, input logic [W-1:0] g, input logic ordy);
        logic accept;
        exp_t r;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.gray_in   = iv ? g : 'x;
        bus.out_ready = ordy;
        #1;
        checkOutput({tag, ".in_ready"}, 32'(bus.in_ready), 32'(!m_valid || ordy));
        checkOutput({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_valid));
        if (m_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput({tag, ".queue_nonempty"}, 32'd0, 32'd1);
            end else begin
                checkOutput({tag, ".result"},
                            32'({bus.binary_out, bus.step_up, bus.step_down, bus.step_err}),
                            32'(exp_q[0]));
            end
            checkOutput({tag, ".onehot"},
                        32'($countones({bus.step_up, bus.step_down, bus.step_err}) <= 1), 32'd1);
            if (ordy && exp_q.size() != 0) void'(exp_q.pop_front());
        end
        accept = iv && (!m_valid || ordy);
        if (accept) begin
            r = model_result(g);
            exp_q.push_back(r);
            m_prev = r.bin;
            m_have = 1'b1;
        end
        m_valid = accept ? 1'b1 : (ordy ? 1'b0 : m_valid);
    endtask

    task automatic feed(input string tag, input logic [W-1:0] g);
        applyStimulus(tag, 1'b1, g, 1'b1);
    endtask

    initial begin
        logic [W-1:0] g_list[5];
        logic [W-1:0] target;
        int           delta;
        tests_run    = 0;
        tests_failed = 0;
        model_reset();

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.gray_in   = '0;
        bus.out_ready = 1'b1;
        #1;
        checkOutput("reset.out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset.binary_out", 32'(bus.binary_out), 32'd0);
        checkOutput("reset.flags", 32'({bus.step_up, bus.step_down, bus.step_err}), 32'd0);
        #1 rst_n = 1'b1;

        $display("[TB] decode sweep");
        g_list = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110};
        foreach (g_list[i]) feed("sweep", g_list[i]);
        applyStimulus("sweep.drain", 1'b0, '0, 1'b1);
        checkOutput("sweep.last_bin", 32'(bus.binary_out), 32'd4);
        checkOutput("sweep.last_up", 32'(bus.step_up), 32'd1);

        $display("[TB] wrap and step down");
        feed("wrap.15", 4'b1000);
        feed("wrap.0", 4'b0000);
        feed("wrap.15b", 4'b1000);
        feed("wrap.0b", 4'b0000);
        applyStimulus("wrap.drain", 1'b0, '0, 1'b1);

        $display("[TB] illegal jump and hold");
        feed("jump.1", 4'b0001);
        feed("jump.4", 4'b0110);
        feed("jump.hold", 4'b0110);
        applyStimulus("jump.drain", 1'b0, '0, 1'b1);

        $display("[TB] backpressure");
        feed("bp.a", 4'b0111);
        for (int i = 0; i < 3; i++) applyStimulus("bp.stall", 1'b1, 4'b0101, 1'b0);
        applyStimulus("bp.release", 1'b1, 4'b0101, 1'b1);
        applyStimulus("bp.next", 1'b1, 4'b0100, 1'b1);
        applyStimulus("bp.drain", 1'b0, '0, 1'b1);

        $display("[TB] async reset mid-cycle");
        feed("rst.pre", 4'b1100);
        @(posedge clk);
        #2;
        bus.in_valid = 1'b1;
        rst_n        = 1'b0;
        #1;
        checkOutput("rst.out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst.binary_out", 32'(bus.binary_out), 32'd0);
        checkOutput("rst.flags", 32'({bus.step_up, bus.step_down, bus.step_err}), 32'd0);
        model_reset();
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        feed("rst.first", 4'b0010);
        applyStimulus("rst.drain", 1'b0, '0, 1'b1);

        $display("[TB] random traffic");
        for (int n = 0; n < 1000; n++) begin
            delta = $urandom_range(0, 9);
            case (delta)
                0, 1, 2: target = m_prev + 4'd1;
                3, 4, 5: target = m_prev - 4'd1;
                6:       target = m_prev;
                default: target = W'($urandom_range(0, 15));
            endcase
            applyStimulus("rand", ($urandom_range(0, 9) < 7), W'(bin2gray(32'(target))),
                          ($urandom_range(0, 9) < 6));
        end
        applyStimulus("rand.drain", 1'b0, '0, 1'b1);
        applyStimulus("rand.idle", 1'b0, '0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
